// File: rtl/wb_arbiter2.sv
// Two-master, one-slave pipelined Wishbone arbiter with outstanding-request throttle and watchdog.
// Optional round-robin tie-break is enabled by defining WB_ARBITER_ROUND_ROBIN_EN.
module wb_arbiter2 #(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned TimeoutCycles  = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  // master 0 (instruction port)
  input  logic [31:0] wb_m0_data_i,
  input  logic [29:0] wb_m0_addr_i,
  input  logic [3:0]  wb_m0_sel_i,
  input  logic        wb_m0_cyc_i,
  input  logic        wb_m0_stb_i,
  input  logic        wb_m0_we_i,
  output logic [31:0] wb_m0_data_o,
  output logic        wb_m0_ack_o,
  output logic        wb_m0_stall_o,
  output logic        wb_m0_err_o,
  // master 1 (data port)
  input  logic [31:0] wb_m1_data_i,
  input  logic [29:0] wb_m1_addr_i,
  input  logic [3:0]  wb_m1_sel_i,
  input  logic        wb_m1_cyc_i,
  input  logic        wb_m1_stb_i,
  input  logic        wb_m1_we_i,
  output logic [31:0] wb_m1_data_o,
  output logic        wb_m1_ack_o,
  output logic        wb_m1_stall_o,
  output logic        wb_m1_err_o,
  // slave
  input  logic [31:0] wb_s_data_i,
  input  logic        wb_s_ack_i,
  input  logic        wb_s_stall_i,
  input  logic        wb_s_err_i,
  output logic [31:0] wb_s_data_o,
  output logic [29:0] wb_s_addr_o,
  output logic [3:0]  wb_s_sel_o,
  output logic        wb_s_cyc_o,
  output logic        wb_s_stb_o,
  output logic        wb_s_we_o
);

  localparam logic [3:0]  MaxOut = 4'(MaxOutstanding);
  localparam logic [15:0] WdLast = 16'(TimeoutCycles - 1);

  typedef enum logic [2:0] {StIdle, StGrant0, StGrant1, StAbort, StDrain} state_e;

  state_e      r_state, w_state_d;
  logic        r_owner, w_owner_d;
  logic [3:0]  r_outstanding, w_outstanding_d;
  logic [15:0] r_wd, w_wd_d;

  logic        w_winner;
  logic        w_grant;
  logic        w_m_cyc, w_m_stb, w_m_we;
  logic [31:0] w_m_data;
  logic [29:0] w_m_addr;
  logic [3:0]  w_m_sel;
  logic        w_s_cyc, w_s_stb, w_accept, w_resp_fwd, w_stall_own, w_err_abort;
  logic        w_own0, w_own1;

  // Owner selects the master in GRANT, ABORT and DRAIN.
  always_comb begin
    w_m_cyc  = r_owner ? wb_m1_cyc_i  : wb_m0_cyc_i;
    w_m_stb  = r_owner ? wb_m1_stb_i  : wb_m0_stb_i;
    w_m_we   = r_owner ? wb_m1_we_i   : wb_m0_we_i;
    w_m_data = r_owner ? wb_m1_data_i : wb_m0_data_i;
    w_m_addr = r_owner ? wb_m1_addr_i : wb_m0_addr_i;
    w_m_sel  = r_owner ? wb_m1_sel_i  : wb_m0_sel_i;
  end

`ifdef WB_ARBITER_ROUND_ROBIN_EN
  logic r_last, w_last_d;

  assign w_winner = (wb_m0_cyc_i & wb_m1_cyc_i) ? ~r_last : wb_m1_cyc_i;

  always_comb begin
    w_last_d = r_last;
    if (r_state == StIdle && (wb_m0_cyc_i || wb_m1_cyc_i)) begin
      w_last_d = w_winner;
    end
  end

  // Reset value m1 makes m0 win the first tie.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_last <= 1'b1;
    end else begin
      r_last <= w_last_d;
    end
  end
`else
  assign w_winner = ~wb_m0_cyc_i;
`endif

  assign w_grant = (r_state == StGrant0) || (r_state == StGrant1);

  always_comb begin
    w_state_d       = r_state;
    w_owner_d       = r_owner;
    w_outstanding_d = r_outstanding;
    w_wd_d          = '0;
    w_s_cyc         = 1'b0;
    w_s_stb         = 1'b0;
    w_accept        = 1'b0;
    w_resp_fwd      = 1'b0;
    w_stall_own     = 1'b1;
    w_err_abort     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (wb_m0_cyc_i || wb_m1_cyc_i) begin
          w_owner_d = w_winner;
          w_state_d = w_winner ? StGrant1 : StGrant0;
        end
      end
      StGrant0, StGrant1: begin
        w_s_cyc     = w_m_cyc;
        w_s_stb     = w_m_cyc & w_m_stb & (r_outstanding < MaxOut);
        w_stall_own = wb_s_stall_i | (r_outstanding == MaxOut);
        if (!w_m_cyc) begin
          // Master abort: anything still in flight is forgotten.
          w_state_d       = StIdle;
          w_outstanding_d = '0;
        end else begin
          w_resp_fwd = (r_outstanding != '0) & (wb_s_ack_i | wb_s_err_i);
          w_accept   = w_s_stb & ~wb_s_stall_i;
          if (w_accept && !w_resp_fwd) begin
            w_outstanding_d = r_outstanding + 4'd1;
          end else if (!w_accept && w_resp_fwd) begin
            w_outstanding_d = r_outstanding - 4'd1;
          end
          if (r_outstanding != '0 && !(wb_s_ack_i || wb_s_err_i)) begin
            if (r_wd == WdLast) begin
              w_state_d = StAbort;
            end else begin
              w_wd_d = r_wd + 16'd1;
            end
          end
        end
      end
      StAbort: begin
        w_err_abort     = 1'b1;
        w_outstanding_d = '0;
        w_state_d       = StDrain;
      end
      StDrain: begin
        if (!w_m_cyc) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state       <= StIdle;
      r_owner       <= 1'b0;
      r_outstanding <= '0;
      r_wd          <= '0;
    end else begin
      r_state       <= w_state_d;
      r_owner       <= w_owner_d;
      r_outstanding <= w_outstanding_d;
      r_wd          <= w_wd_d;
    end
  end

  // Reset forces IDLE-valued outputs in the same cycle.
  assign w_own0 = ~r_owner & ~reset_i;
  assign w_own1 =  r_owner & ~reset_i;

  assign wb_s_cyc_o  = w_s_cyc & ~reset_i;
  assign wb_s_stb_o  = w_s_stb & ~reset_i;
  assign wb_s_we_o   = w_grant & w_m_we & ~reset_i;
  assign wb_s_data_o = (w_grant && !reset_i) ? w_m_data : '0;
  assign wb_s_addr_o = (w_grant && !reset_i) ? w_m_addr : '0;
  assign wb_s_sel_o  = (w_grant && !reset_i) ? w_m_sel  : '0;

  assign wb_m0_stall_o = w_own0 ? w_stall_own : 1'b1;
  assign wb_m0_ack_o   = w_own0 & w_resp_fwd & wb_s_ack_i;
  assign wb_m0_err_o   = w_own0 & ((w_resp_fwd & wb_s_err_i) | w_err_abort);
  assign wb_m0_data_o  = (w_own0 && w_resp_fwd) ? wb_s_data_i : '0;

  assign wb_m1_stall_o = w_own1 ? w_stall_own : 1'b1;
  assign wb_m1_ack_o   = w_own1 & w_resp_fwd & wb_s_ack_i;
  assign wb_m1_err_o   = w_own1 & ((w_resp_fwd & wb_s_err_i) | w_err_abort);
  assign wb_m1_data_o  = (w_own1 && w_resp_fwd) ? wb_s_data_i : '0;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 (MaxOutstanding=2, TimeoutCycles=8) with a read-data scoreboard.
module tb_wb_arbiter2;
  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic [29:0] m0_addr, m1_addr;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic        m0_ack, m0_stall, m0_err, m1_ack, m1_stall, m1_err;
  logic [31:0] s_rdata, s_wdata;
  logic        s_ack, s_stall, s_err;
  logic [29:0] s_addr;
  logic [3:0]  s_sel;
  logic        s_cyc, s_stb, s_we;

  int checks = 0;
  int errors = 0;
  logic [29:0] slave_q[$];
  logic [31:0] exp_q[$];
  int n_sent, n_acks;

  always #5 clk = ~clk;

  wb_arbiter2 #(.MaxOutstanding(2), .TimeoutCycles(8)) u_dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .wb_m0_data_i (m0_wdata),
    .wb_m0_addr_i (m0_addr),
    .wb_m0_sel_i  (m0_sel),
    .wb_m0_cyc_i  (m0_cyc),
    .wb_m0_stb_i  (m0_stb),
    .wb_m0_we_i   (m0_we),
    .wb_m0_data_o (m0_rdata),
    .wb_m0_ack_o  (m0_ack),
    .wb_m0_stall_o(m0_stall),
    .wb_m0_err_o  (m0_err),
    .wb_m1_data_i (m1_wdata),
    .wb_m1_addr_i (m1_addr),
    .wb_m1_sel_i  (m1_sel),
    .wb_m1_cyc_i  (m1_cyc),
    .wb_m1_stb_i  (m1_stb),
    .wb_m1_we_i   (m1_we),
    .wb_m1_data_o (m1_rdata),
    .wb_m1_ack_o  (m1_ack),
    .wb_m1_stall_o(m1_stall),
    .wb_m1_err_o  (m1_err),
    .wb_s_data_i  (s_rdata),
    .wb_s_ack_i   (s_ack),
    .wb_s_stall_i (s_stall),
    .wb_s_err_i   (s_err),
    .wb_s_data_o  (s_wdata),
    .wb_s_addr_o  (s_addr),
    .wb_s_sel_o   (s_sel),
    .wb_s_cyc_o   (s_cyc),
    .wb_s_stb_o   (s_stb),
    .wb_s_we_o    (s_we)
  );

  function automatic logic [31:0] mem(input logic [29:0] a);
    return 32'hC0DE_0000 ^ {2'b00, a} ^ ({2'b00, a} << 20);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    logic [31:0] exp_tie2;
    reset_i = 1'b1;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
    m0_addr = '0; m1_addr = '0; m0_sel = 4'hF; m1_sel = 4'h3;
    m0_wdata = 32'h1111_0000; m1_wdata = 32'h2222_0000;
    s_rdata = '0; s_ack = 1'b0; s_stall = 1'b0; s_err = 1'b0;
    tick(); tick();
    reset_i = 1'b0;
    settle();
    chk("rst_stall0", m0_stall, 1);
    chk("rst_stall1", m1_stall, 1);
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_ack_err", {m0_ack, m0_err, m1_ack, m1_err}, 0);

    // Three pipelined reads from m0 against a slave that acks one cycle after accept.
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 30'h10;
    settle();
    chk("t1_idle_s_cyc", s_cyc, 0);
    chk("t1_idle_stall0", m0_stall, 1);
    n_sent = 0; n_acks = 0;
    for (int c = 0; c < 12 && n_acks < 3; c++) begin
      tick();
      if (slave_q.size() > 0) begin
        s_ack = 1'b1; s_rdata = mem(slave_q.pop_front());
      end else begin
        s_ack = 1'b0; s_rdata = '0;
      end
      m0_stb = (n_sent < 3);
      m0_addr = 30'h10 + 30'(n_sent);
      settle();
      if (c == 0) begin
        chk("t1_grant_s_cyc", s_cyc, 1);
        chk("t1_sel_pass", s_sel, 4'hF);
      end
      chk("t1_m1_stall", m1_stall, 1);
      if (m0_ack) begin
        if (exp_q.size() == 0) begin
          chk("t1_unexpected_ack", 1, 0);
        end else begin
          chk("t1_rdata", m0_rdata, exp_q.pop_front());
        end
        n_acks++;
      end
      if (s_stb && !s_stall) begin
        slave_q.push_back(s_addr);
        exp_q.push_back(mem(m0_addr));
        n_sent++;
      end
    end
    chk("t1_ack_count", n_acks, 3);
    chk("t1_sb_empty", exp_q.size(), 0);
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0; s_rdata = '0;
    settle();
    chk("t1_release_s_cyc", s_cyc, 0);
    tick(); settle();
    chk("t1_idle_after", m0_stall, 1);

    // Outstanding limit of 2.
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 30'h20;
    tick(); settle();
    chk("t2_acc0", m0_stall, 0);
    tick(); m0_addr = 30'h21; settle();
    chk("t2_acc1", m0_stall, 0);
    tick(); m0_addr = 30'h22; settle();
    chk("t2_full_stall", m0_stall, 1);
    chk("t2_full_stb", s_stb, 0);
    tick(); s_ack = 1'b1; s_rdata = mem(30'h20); settle();
    chk("t2_ack0", m0_ack, 1);
    chk("t2_data0", m0_rdata, mem(30'h20));
    chk("t2_full_stall2", m0_stall, 1);
    tick(); s_ack = 1'b0; s_rdata = '0; settle();
    chk("t2_third_stall", m0_stall, 0);
    chk("t2_third_stb", s_stb, 1);
    chk("t2_third_addr", s_addr, 30'h22);
    tick(); m0_stb = 1'b0; s_ack = 1'b1; s_rdata = mem(30'h21); settle();
    chk("t2_ack1", m0_ack, 1);
    chk("t2_data1", m0_rdata, mem(30'h21));
    tick(); s_ack = 1'b0; s_err = 1'b1; settle();
    chk("t2_err_fwd", m0_err, 1);
    chk("t2_err_noack", m0_ack, 0);
    tick(); s_err = 1'b0; m0_cyc = 1'b0; settle();
    tick(); settle();

    // Tie twice, starting from reset so last-grant is m1.
    reset_i = 1'b1;
    tick(); reset_i = 1'b0;
    m0_cyc = 1'b1; m1_cyc = 1'b1; m0_addr = 30'h100; m1_addr = 30'h200;
    settle();
    chk("t3_idle_s_cyc", s_cyc, 0);
    tick(); settle();
    chk("t3_tie1_addr", s_addr, 30'h100);
    chk("t3_tie1_stall1", m1_stall, 1);
    chk("t3_tie1_stall0", m0_stall, 0);
    tick(); m0_cyc = 1'b0; m1_cyc = 1'b0; settle();
    chk("t3_drop_s_cyc", s_cyc, 0);
    tick(); m0_cyc = 1'b1; m1_cyc = 1'b1; settle();
    chk("t3_bubble_s_cyc", s_cyc, 0);
    chk("t3_bubble_stall", {m0_stall, m1_stall}, 2'b11);
    tick(); settle();
`ifdef WB_ARBITER_ROUND_ROBIN_EN
    exp_tie2 = 32'h200;
`else
    exp_tie2 = 32'h100;
`endif
    chk("t3_tie2_addr", s_addr, exp_tie2);
    chk("t3_tie2_s_cyc", s_cyc, 1);
    tick(); m0_cyc = 1'b0; m1_cyc = 1'b0; settle();
    tick(); settle();

    // Watchdog timeout after one unanswered read.
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 30'h30;
    tick(); settle();
    chk("t4_accept", m0_stall, 0);
    for (int k = 1; k <= 8; k++) begin
      tick(); m0_stb = 1'b0; settle();
      chk("t4_no_err", m0_err, 0);
      chk("t4_wait_s_cyc", s_cyc, 1);
    end
    tick(); settle();
    chk("t4_err", m0_err, 1);
    chk("t4_abort_s_cyc", s_cyc, 0);
    tick(); s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF; settle();
    chk("t4_late_ack", m0_ack, 0);
    chk("t4_drain_err", m0_err, 0);
    chk("t4_drain_stall", m0_stall, 1);
    tick(); s_ack = 1'b0; m0_cyc = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 30'h40;
    settle();
    chk("t4_drain_s_cyc", s_cyc, 0);
    tick(); settle();
    chk("t4_idle_stall1", m1_stall, 1);
    chk("t4_idle_s_cyc", s_cyc, 0);

    // Reset during GRANT1 with two outstanding.
    tick(); settle();
    chk("t5_grant1_addr", s_addr, 30'h40);
    chk("t5_acc0", m1_stall, 0);
    tick(); m1_addr = 30'h41; settle();
    chk("t5_acc1", m1_stall, 0);
    tick(); m1_stb = 1'b0; reset_i = 1'b1; settle();
    tick(); reset_i = 1'b0; settle();
    chk("t5_rst_stall1", m1_stall, 1);
    chk("t5_rst_s_cyc", s_cyc, 0);
    tick(); s_ack = 1'b1; m1_stb = 1'b1; m1_addr = 30'h50; settle();
    chk("t5_out_zero_ack", m1_ack, 0);
    chk("t5_regrant_stall", m1_stall, 0);

    // Master abort from m1 with one outstanding; m0 waiting.
    tick(); s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b0; m0_addr = 30'h60;
    settle();
    chk("t6_abort_s_cyc", s_cyc, 0);
    chk("t6_abort_stall0", m0_stall, 1);
    tick(); s_ack = 1'b1; s_rdata = 32'h5555_AAAA; settle();
    chk("t6_drop_ack1", m1_ack, 0);
    chk("t6_drop_ack0", m0_ack, 0);
    tick(); settle();
    chk("t6_m0_grant_addr", s_addr, 30'h60);
    chk("t6_m0_grant_cyc", s_cyc, 1);
    chk("t6_m0_stall", m0_stall, 0);
    chk("t6_m0_no_ack", m0_ack, 0);
    tick(); s_ack = 1'b0; m0_cyc = 1'b0; settle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
